// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue
//  Description : DEPTH-entry instruction ring between fetch and dispatch with
//                a single registered RV32I decode stage on the output side.
//                Flags illegal encodings and supports flush and global pause.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int NAME_W = 6
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_pc,
    input  logic              in_pred_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [NAME_W-1:0] out_name,
    output logic [2:0]        out_type,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [31:0]       out_imm,
    output logic              out_is_imm,
    output logic              out_is_pc,
    output logic              out_pred_taken,
    output logic              out_illegal,
    output logic [ADDR_W:0]   count
);

    // Operation name codes
    localparam logic [NAME_W-1:0] c_N_LUI   = NAME_W'(1);
    localparam logic [NAME_W-1:0] c_N_AUIPC = NAME_W'(2);
    localparam logic [NAME_W-1:0] c_N_JAL   = NAME_W'(3);
    localparam logic [NAME_W-1:0] c_N_JALR  = NAME_W'(4);
    localparam logic [NAME_W-1:0] c_N_BEQ   = NAME_W'(5);
    localparam logic [NAME_W-1:0] c_N_BNE   = NAME_W'(6);
    localparam logic [NAME_W-1:0] c_N_BLT   = NAME_W'(7);
    localparam logic [NAME_W-1:0] c_N_BGE   = NAME_W'(8);
    localparam logic [NAME_W-1:0] c_N_BLTU  = NAME_W'(9);
    localparam logic [NAME_W-1:0] c_N_BGEU  = NAME_W'(10);
    localparam logic [NAME_W-1:0] c_N_LB    = NAME_W'(11);
    localparam logic [NAME_W-1:0] c_N_LH    = NAME_W'(12);
    localparam logic [NAME_W-1:0] c_N_LW    = NAME_W'(13);
    localparam logic [NAME_W-1:0] c_N_LBU   = NAME_W'(14);
    localparam logic [NAME_W-1:0] c_N_LHU   = NAME_W'(15);
    localparam logic [NAME_W-1:0] c_N_SB    = NAME_W'(16);
    localparam logic [NAME_W-1:0] c_N_SH    = NAME_W'(17);
    localparam logic [NAME_W-1:0] c_N_SW    = NAME_W'(18);
    localparam logic [NAME_W-1:0] c_N_ADDI  = NAME_W'(19);
    localparam logic [NAME_W-1:0] c_N_SLTI  = NAME_W'(20);
    localparam logic [NAME_W-1:0] c_N_SLTIU = NAME_W'(21);
    localparam logic [NAME_W-1:0] c_N_XORI  = NAME_W'(22);
    localparam logic [NAME_W-1:0] c_N_ORI   = NAME_W'(23);
    localparam logic [NAME_W-1:0] c_N_ANDI  = NAME_W'(24);
    localparam logic [NAME_W-1:0] c_N_SLLI  = NAME_W'(25);
    localparam logic [NAME_W-1:0] c_N_SRLI  = NAME_W'(26);
    localparam logic [NAME_W-1:0] c_N_SRAI  = NAME_W'(27);
    localparam logic [NAME_W-1:0] c_N_ADD   = NAME_W'(28);
    localparam logic [NAME_W-1:0] c_N_SUB   = NAME_W'(29);
    localparam logic [NAME_W-1:0] c_N_SLL   = NAME_W'(30);
    localparam logic [NAME_W-1:0] c_N_SLT   = NAME_W'(31);
    localparam logic [NAME_W-1:0] c_N_SLTU  = NAME_W'(32);
    localparam logic [NAME_W-1:0] c_N_XOR   = NAME_W'(33);
    localparam logic [NAME_W-1:0] c_N_SRL   = NAME_W'(34);
    localparam logic [NAME_W-1:0] c_N_SRA   = NAME_W'(35);
    localparam logic [NAME_W-1:0] c_N_OR    = NAME_W'(36);
    localparam logic [NAME_W-1:0] c_N_AND   = NAME_W'(37);

    // Operation classes
    localparam logic [2:0] c_T_ALU    = 3'd0;
    localparam logic [2:0] c_T_LOAD   = 3'd1;
    localparam logic [2:0] c_T_STORE  = 3'd2;
    localparam logic [2:0] c_T_BRANCH = 3'd3;
    localparam logic [2:0] c_T_JUMP   = 3'd4;

    // Major opcodes (full 7 bits, so i[1:0]!=2'b11 never matches)
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    localparam logic [ADDR_W:0]   c_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);
    localparam logic [6:0]        c_F7_ZERO = 7'b0000000;
    localparam logic [6:0]        c_F7_ALT  = 7'b0100000;

    // Ring storage and bookkeeping
    logic [31:0]       r_ring_inst [DEPTH];
    logic [31:0]       r_ring_pc   [DEPTH];
    logic              r_ring_pred [DEPTH];
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_cnt;

    // Output register
    logic              r_out_valid;
    logic [31:0]       r_out_pc;
    logic [NAME_W-1:0] r_out_name;
    logic [2:0]        r_out_type;
    logic [4:0]        r_out_rd;
    logic [4:0]        r_out_rs1;
    logic [4:0]        r_out_rs2;
    logic [31:0]       r_out_imm;
    logic              r_out_is_imm;
    logic              r_out_is_pc;
    logic              r_out_pred;
    logic              r_out_illegal;

    logic              w_in_ready;
    logic              w_flush;
    logic              w_push;
    logic              w_load;
    logic              w_drain;

    // Decode of the head entry
    logic [31:0]       w_inst;
    logic [6:0]        w_op;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [31:0]       w_imm_i;
    logic [31:0]       w_imm_s;
    logic [31:0]       w_imm_b;
    logic [31:0]       w_imm_u;
    logic [31:0]       w_imm_j;
    logic [NAME_W-1:0] w_name;
    logic [2:0]        w_type;
    logic [4:0]        w_rd;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [31:0]       w_imm;
    logic              w_is_imm;
    logic              w_is_pc;
    logic              w_ill;

    // Handshake qualifiers; flush and pause dominate every other action
    assign w_in_ready = rdy_in && (r_cnt != c_FULL);
    assign w_flush    = rdy_in && flush_in;
    assign w_push     = in_valid && w_in_ready && !flush_in;
    assign w_load     = rdy_in && !flush_in && (r_cnt != '0) && (!r_out_valid || out_ready);
    assign w_drain    = rdy_in && !flush_in && r_out_valid && out_ready && (r_cnt == '0);

    assign w_inst  = r_ring_inst[r_head];
    assign w_op    = w_inst[6:0];
    assign w_f3    = w_inst[14:12];
    assign w_f7    = w_inst[31:25];
    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    // Fully decode the head instruction; unused register fields read as zero
    always_comb begin
        w_name   = c_N_ADDI;
        w_type   = c_T_ALU;
        w_rd     = w_inst[11:7];
        w_rs1    = w_inst[19:15];
        w_rs2    = w_inst[24:20];
        w_imm    = '0;
        w_is_imm = 1'b0;
        w_is_pc  = 1'b0;
        w_ill    = 1'b0;
        case (w_op)
            c_OPC_LUI: begin
                w_name   = c_N_LUI;
                w_rs1    = '0;
                w_rs2    = '0;
                w_imm    = w_imm_u;
                w_is_imm = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_name   = c_N_AUIPC;
                w_rs1    = '0;
                w_rs2    = '0;
                w_imm    = w_imm_u;
                w_is_imm = 1'b1;
                w_is_pc  = 1'b1;
            end
            c_OPC_JAL: begin
                w_name   = c_N_JAL;
                w_type   = c_T_JUMP;
                w_rs1    = '0;
                w_rs2    = '0;
                w_imm    = w_imm_j;
                w_is_imm = 1'b1;
                w_is_pc  = 1'b1;
            end
            c_OPC_JALR: begin
                w_name   = c_N_JALR;
                w_type   = c_T_JUMP;
                w_rs2    = '0;
                w_imm    = w_imm_i;
                w_is_imm = 1'b1;
                if (w_f3 != 3'b000) w_ill = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_type = c_T_BRANCH;
                w_rd   = '0;
                w_imm  = w_imm_b;
                case (w_f3)
                    3'b000:  w_name = c_N_BEQ;
                    3'b001:  w_name = c_N_BNE;
                    3'b100:  w_name = c_N_BLT;
                    3'b101:  w_name = c_N_BGE;
                    3'b110:  w_name = c_N_BLTU;
                    3'b111:  w_name = c_N_BGEU;
                    default: w_ill  = 1'b1;
                endcase
            end
            c_OPC_LOAD: begin
                w_type   = c_T_LOAD;
                w_rs2    = '0;
                w_imm    = w_imm_i;
                w_is_imm = 1'b1;
                case (w_f3)
                    3'b000:  w_name = c_N_LB;
                    3'b001:  w_name = c_N_LH;
                    3'b010:  w_name = c_N_LW;
                    3'b100:  w_name = c_N_LBU;
                    3'b101:  w_name = c_N_LHU;
                    default: w_ill  = 1'b1;
                endcase
            end
            c_OPC_STORE: begin
                w_type   = c_T_STORE;
                w_rd     = '0;
                w_imm    = w_imm_s;
                w_is_imm = 1'b1;
                case (w_f3)
                    3'b000:  w_name = c_N_SB;
                    3'b001:  w_name = c_N_SH;
                    3'b010:  w_name = c_N_SW;
                    default: w_ill  = 1'b1;
                endcase
            end
            c_OPC_OPIMM: begin
                w_rs2    = '0;
                w_imm    = w_imm_i;
                w_is_imm = 1'b1;
                case (w_f3)
                    3'b000: w_name = c_N_ADDI;
                    3'b010: w_name = c_N_SLTI;
                    3'b011: w_name = c_N_SLTIU;
                    3'b100: w_name = c_N_XORI;
                    3'b110: w_name = c_N_ORI;
                    3'b111: w_name = c_N_ANDI;
                    3'b001: begin
                        // Shift immediates carry only the 5-bit shamt
                        w_name = c_N_SLLI;
                        w_imm  = {27'b0, w_inst[24:20]};
                        if (w_f7 != c_F7_ZERO) w_ill = 1'b1;
                    end
                    default: begin
                        w_imm = {27'b0, w_inst[24:20]};
                        if (w_f7 == c_F7_ZERO)     w_name = c_N_SRLI;
                        else if (w_f7 == c_F7_ALT) w_name = c_N_SRAI;
                        else                       w_ill  = 1'b1;
                    end
                endcase
            end
            c_OPC_OP: begin
                if (w_f7 == c_F7_ZERO) begin
                    case (w_f3)
                        3'b000:  w_name = c_N_ADD;
                        3'b001:  w_name = c_N_SLL;
                        3'b010:  w_name = c_N_SLT;
                        3'b011:  w_name = c_N_SLTU;
                        3'b100:  w_name = c_N_XOR;
                        3'b101:  w_name = c_N_SRL;
                        3'b110:  w_name = c_N_OR;
                        default: w_name = c_N_AND;
                    endcase
                end else if (w_f7 == c_F7_ALT) begin
                    case (w_f3)
                        3'b000:  w_name = c_N_SUB;
                        3'b101:  w_name = c_N_SRA;
                        default: w_ill  = 1'b1;
                    endcase
                end else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal encodings travel as a harmless ADDI x0 so dispatch can trap on them
        if (w_ill) begin
            w_name   = c_N_ADDI;
            w_type   = c_T_ALU;
            w_rd     = '0;
            w_rs1    = '0;
            w_rs2    = '0;
            w_imm    = '0;
            w_is_imm = 1'b0;
            w_is_pc  = 1'b0;
        end
    end

    // Ring payload storage; contents are meaningless outside head..tail
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_ring_inst[r_tail] <= in_inst;
            r_ring_pc[r_tail]   <= in_pc;
            r_ring_pred[r_tail] <= in_pred_taken;
        end
    end

    // Ring pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else if (w_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + c_PTR_ONE;
            if (w_load) r_head <= r_head + c_PTR_ONE;
            if (w_push && !w_load)      r_cnt <= r_cnt + c_CNT_ONE;
            else if (!w_push && w_load) r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // Output register: capture the decoded head, hold while dispatch stalls
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_out_valid   <= 1'b0;
            r_out_pc      <= '0;
            r_out_name    <= '0;
            r_out_type    <= '0;
            r_out_rd      <= '0;
            r_out_rs1     <= '0;
            r_out_rs2     <= '0;
            r_out_imm     <= '0;
            r_out_is_imm  <= 1'b0;
            r_out_is_pc   <= 1'b0;
            r_out_pred    <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (w_flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_out_pc      <= r_ring_pc[r_head];
            r_out_name    <= w_name;
            r_out_type    <= w_type;
            r_out_rd      <= w_rd;
            r_out_rs1     <= w_rs1;
            r_out_rs2     <= w_rs2;
            r_out_imm     <= w_imm;
            r_out_is_imm  <= w_is_imm;
            r_out_is_pc   <= w_is_pc;
            r_out_pred    <= r_ring_pred[r_head];
            r_out_illegal <= w_ill;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = r_out_valid;
    assign out_pc         = r_out_pc;
    assign out_name       = r_out_name;
    assign out_type       = r_out_type;
    assign out_rd         = r_out_rd;
    assign out_rs1        = r_out_rs1;
    assign out_rs2        = r_out_rs2;
    assign out_imm        = r_out_imm;
    assign out_is_imm     = r_out_is_imm;
    assign out_is_pc      = r_out_is_pc;
    assign out_pred_taken = r_out_pred;
    assign out_illegal    = r_out_illegal;
    assign count          = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_queue
//  Description : Self-checking bench for decode_queue with a queue-based
//                reference model and a table-driven RV32I reference decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int NAME_W = 6;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    typedef struct packed {
        logic [5:0]  name;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        is_imm;
        logic        is_pc;
        logic        ill;
        logic        use_rs1;
        logic        use_rs2;
    } dec_t;

    logic              clk_in;
    logic              rst_n_in;
    logic              rdy_in;
    logic              flush_in;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [31:0]       in_pc;
    logic              in_pred_taken;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [NAME_W-1:0] out_name;
    logic [2:0]        out_type;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [31:0]       out_imm;
    logic              out_is_imm;
    logic              out_is_pc;
    logic              out_pred_taken;
    logic              out_illegal;
    logic [ADDR_W:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: ring contents and output register
    entry_t mq[$];
    entry_t m_out;
    logic   m_ov;

    decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NAME_W(NAME_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_pred_taken(in_pred_taken), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_name(out_name), .out_type(out_type), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_is_imm(out_is_imm),
        .out_is_pc(out_is_pc), .out_pred_taken(out_pred_taken), .out_illegal(out_illegal),
        .count(count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Table-driven reference decoder (names: 1 LUI .. 37 AND, -1 = no such op)
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        int br[8];
        int ld[8];
        int st[8];
        int oi[8];
        int op[8];
        int nm;
        logic [2:0] f3;
        logic [6:0] f7;
        br = '{5, 6, -1, -1, 7, 8, 9, 10};
        ld = '{11, 12, 13, -1, 14, 15, -1, -1};
        st = '{16, 17, 18, -1, -1, -1, -1, -1};
        oi = '{19, -1, 20, 21, 22, -1, 23, 24};
        op = '{28, 30, 31, 32, 33, 34, 36, 37};
        f3 = i[14:12];
        f7 = i[31:25];
        d = '0;
        nm = -1;
        d.rd = i[11:7];
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        case (i[6:0])
            7'h37: begin nm = 1; d.imm = {i[31:12], 12'b0}; d.is_imm = 1'b1; end
            7'h17: begin nm = 2; d.imm = {i[31:12], 12'b0}; d.is_imm = 1'b1; d.is_pc = 1'b1; end
            7'h6F: begin
                nm = 3; d.typ = 3'd4; d.is_imm = 1'b1; d.is_pc = 1'b1;
                d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h67: begin
                if (f3 == 3'd0) nm = 4;
                d.typ = 3'd4; d.imm = {{20{i[31]}}, i[31:20]}; d.is_imm = 1'b1; d.use_rs1 = 1'b1;
            end
            7'h63: begin
                nm = br[f3]; d.typ = 3'd3; d.rd = '0; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'h03: begin
                nm = ld[f3]; d.typ = 3'd1; d.imm = {{20{i[31]}}, i[31:20]};
                d.is_imm = 1'b1; d.use_rs1 = 1'b1;
            end
            7'h23: begin
                nm = st[f3]; d.typ = 3'd2; d.rd = '0; d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                d.is_imm = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
            end
            7'h13: begin
                d.is_imm = 1'b1; d.use_rs1 = 1'b1; d.imm = {{20{i[31]}}, i[31:20]};
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    d.imm = {27'b0, i[24:20]};
                    if (f7 == 7'h00)                     nm = (f3 == 3'd1) ? 25 : 26;
                    else if (f7 == 7'h20 && f3 == 3'd5) nm = 27;
                end else begin
                    nm = oi[f3];
                end
            end
            7'h33: begin
                d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
                if (f7 == 7'h00)      nm = op[f3];
                else if (f7 == 7'h20) nm = (f3 == 3'd0) ? 29 : ((f3 == 3'd5) ? 35 : -1);
            end
            default: nm = -1;
        endcase
        if (nm < 0) begin
            d = '0;
            d.name = 6'd19;
            d.ill = 1'b1;
        end else begin
            d.name = 6'(nm);
        end
        return d;
    endfunction

    // Mostly well-formed instructions with random fields, plus raw noise
    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  opc[10];
        int k;
        opc = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h13};
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) begin
            r[6:0] = opc[k];
            if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
        return r;
    endfunction

    // Advance one clock and the model with it, using the inputs as driven now
    task automatic step();
        logic   ps, ld, dr, fl;
        entry_t e;
        e  = '{inst: in_inst, pc: in_pc, pred: in_pred_taken};
        fl = rdy_in && flush_in;
        ps = in_valid && rdy_in && !flush_in && (mq.size() != DEPTH);
        ld = rdy_in && !flush_in && (mq.size() != 0) && (!m_ov || out_ready);
        dr = rdy_in && !flush_in && m_ov && out_ready && (mq.size() == 0);
        @(posedge clk_in);
        #1;
        if (fl) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            if (ld) begin
                m_out = mq.pop_front();
                m_ov = 1'b1;
            end else if (dr) begin
                m_ov = 1'b0;
            end
            if (ps) mq.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; in_pred_taken = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        mq.delete(); m_ov = 1'b0;
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: count=%0d out_valid=%0b, required 0/0", count, out_valid);
        end
        n_checks++;
        if ({out_pc, out_name, out_type, out_rd, out_rs1, out_rs2, out_imm, out_is_imm,
             out_is_pc, out_pred_taken, out_illegal} !== '0) begin
            n_errors++;
            $display("FAIL reset_fields: pc=%h name=%0d imm=%h ill=%0b, required all zero",
                     out_pc, out_name, out_imm, out_illegal);
        end
        rst_n_in = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_decode_directed();
        logic [31:0] insts [4];
        int          e_name[4], e_type[4], e_rd[4], e_rs1[4], e_rs2[4];
        logic [31:0] e_imm [4];
        logic        e_ill [4], e_isimm[4], e_ispc[4];
        insts  = '{32'h00500093, 32'hFF9FF0EF, 32'hFE21AE23, 32'h00000000};
        e_name = '{19, 3, 18, 19};
        e_type = '{0, 4, 2, 0};
        e_rd   = '{1, 1, 0, 0};
        e_rs1  = '{0, -1, 3, -1};
        e_rs2  = '{-1, -1, 2, -1};
        e_imm  = '{32'd5, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'd0};
        e_ill  = '{1'b0, 1'b0, 1'b0, 1'b1};
        e_isimm = '{1'b1, 1'b1, 1'b1, 1'b0};
        e_ispc  = '{1'b0, 1'b1, 1'b0, 1'b0};
        idle_inputs();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = insts[k]; in_pc = 32'h100 + 32'(4 * k);
            step();
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || count !== 4'd1) begin
                n_errors++;
                $display("FAIL latency_%0d: out_valid=%0b count=%0d, required 0/1", k, out_valid, count);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_name !== 6'(e_name[k]) || out_type !== 3'(e_type[k]) ||
                out_rd !== 5'(e_rd[k]) || out_illegal !== e_ill[k] || out_pc !== (32'h100 + 32'(4 * k))) begin
                n_errors++;
                $display("FAIL decode_%0d: v=%0b name=%0d type=%0d rd=%0d ill=%0b pc=%h, required 1/%0d/%0d/%0d/%0b",
                         k, out_valid, out_name, out_type, out_rd, out_illegal, out_pc,
                         e_name[k], e_type[k], e_rd[k], e_ill[k]);
            end
            if (!e_ill[k]) begin
                n_checks++;
                if (out_imm !== e_imm[k] || out_is_imm !== e_isimm[k] || out_is_pc !== e_ispc[k]) begin
                    n_errors++;
                    $display("FAIL imm_%0d: imm=%h is_imm=%0b is_pc=%0b, required %h/%0b/%0b",
                             k, out_imm, out_is_imm, out_is_pc, e_imm[k], e_isimm[k], e_ispc[k]);
                end
            end
            if (e_rs1[k] >= 0 || e_rs2[k] >= 0) begin
                n_checks++;
                if ((e_rs1[k] >= 0 && out_rs1 !== 5'(e_rs1[k])) || (e_rs2[k] >= 0 && out_rs2 !== 5'(e_rs2[k]))) begin
                    n_errors++;
                    $display("FAIL regs_%0d: rs1=%0d rs2=%0d, required %0d/%0d", k, out_rs1, out_rs2, e_rs1[k], e_rs2[k]);
                end
            end
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL drain_%0d: out_valid=%0b required 0", k, out_valid);
            end
        end
    endtask

    task automatic test_full_flush();
        idle_inputs();
        for (int k = 0; k < DEPTH + 1; k++) begin
            in_valid = 1'b1; in_inst = rand_inst(); in_pc = 32'h2000 + 32'(4 * k);
            step();
        end
        n_checks++;
        if (count !== 4'(DEPTH) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL full: count=%0d in_ready=%0b out_valid=%0b, required %0d/0/1",
                     count, in_ready, out_valid, DEPTH);
        end
        // Full with a pop this cycle: still no push-through
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_pop_ready: in_ready=%0b required 0", in_ready);
        end
        step();
        n_checks++;
        if (count !== 4'(DEPTH - 1) || out_pc !== 32'h2004) begin
            n_errors++;
            $display("FAIL full_pop: count=%0d pc=%h, required %0d/00002004", count, out_pc, DEPTH - 1);
        end
        out_ready = 1'b0; flush_in = 1'b1; in_valid = 1'b1;
        step();
        flush_in = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush: count=%0d out_valid=%0b, required 0/0", count, out_valid);
        end
        // Resume across the pointer wrap; order must match the model
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            in_inst = rand_inst(); in_pc = 32'h3000 + 32'(4 * k); in_pred_taken = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            n_checks++;
            if (out_valid !== m_ov || count !== 4'(mq.size()) || (m_ov && out_pc !== m_out.pc)) begin
                n_errors++;
                $display("FAIL wrap_order_%0d: v=%0b cnt=%0d pc=%h, required %0b/%0d/%h",
                         k, out_valid, count, out_pc, m_ov, mq.size(), m_out.pc);
            end
        end
    endtask

    task automatic test_random();
        dec_t d;
        for (int c = 0; c < 500; c++) begin
            rdy_in    = ($urandom_range(0, 9) != 0);
            flush_in  = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 5);
            in_inst = rand_inst(); in_pc = $urandom; in_pred_taken = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (in_ready !== (rdy_in && (mq.size() != DEPTH))) begin
                n_errors++;
                $display("FAIL rnd_in_ready_%0d: got %0b required %0b", c, in_ready, rdy_in && (mq.size() != DEPTH));
            end
            step();
            n_checks++;
            if (count !== 4'(mq.size()) || out_valid !== m_ov) begin
                n_errors++;
                $display("FAIL rnd_state_%0d: count=%0d v=%0b, required %0d/%0b", c, count, out_valid, mq.size(), m_ov);
            end
            if (m_ov) begin
                d = ref_decode(m_out.inst);
                n_checks++;
                if (out_pc !== m_out.pc || out_pred_taken !== m_out.pred || out_name !== d.name ||
                    out_type !== d.typ || out_rd !== d.rd || out_illegal !== d.ill) begin
                    n_errors++;
                    $display("FAIL rnd_decode_%0d inst=%h: pc=%h pred=%0b name=%0d type=%0d rd=%0d ill=%0b, required %h/%0b/%0d/%0d/%0d/%0b",
                             c, m_out.inst, out_pc, out_pred_taken, out_name, out_type, out_rd, out_illegal,
                             m_out.pc, m_out.pred, d.name, d.typ, d.rd, d.ill);
                end
                if (!d.ill) begin
                    n_checks++;
                    if (out_imm !== d.imm || out_is_imm !== d.is_imm || out_is_pc !== d.is_pc ||
                        (d.use_rs1 && out_rs1 !== d.rs1) || (d.use_rs2 && out_rs2 !== d.rs2)) begin
                        n_errors++;
                        $display("FAIL rnd_operands_%0d inst=%h: imm=%h is_imm=%0b is_pc=%0b rs1=%0d rs2=%0d, required %h/%0b/%0b/%0d/%0d",
                                 c, m_out.inst, out_imm, out_is_imm, out_is_pc, out_rs1, out_rs2,
                                 d.imm, d.is_imm, d.is_pc, d.rs1, d.rs2);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'(k);
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n_in = 1'b0;
        #1;
        mq.delete(); m_ov = 1'b0;
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset: count=%0d out_valid=%0b, required 0/0", count, out_valid);
        end
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || count !== 4'd0) begin
            n_errors++;
            $display("FAIL midreset_release: in_ready=%0b count=%0d, required 1/0", in_ready, count);
        end
    endtask

    initial begin
        m_ov = 1'b0;
        m_out = '0;
        rst_n_in = 1'b0;
        idle_inputs();
        test_reset();
        test_decode_directed();
        test_full_flush();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
